flash_burst_arbiter: RTL and testbench
======================================

# flash_burst_arbiter

Shares one DSPI flash byte reader between two requesters (e.g. the UART command path and a boot/prefetch loader) and sequences multi-byte bursts. A requester posts a start address and byte count. The arbiter issues one single-byte read per byte to the reader and returns each byte through a per-requester valid/ready handshake. It sits between the top-level control logic and the flash reader, and owns the reader's `read`/`addr` inputs.

## Interface
- `ADDR_W`, 24: flash byte address width.
- `LEN_W`, 8: burst length width; a burst is 0..2^LEN_W-1 bytes.
- `SETTLE_CYC`, 32: post-reset quiet time in cycles. Must exceed the reader's longest transaction (28 cycles).
- `clk  in  1`: system clock. Same clock as the flash reader, which uses it as SCLK.
- `rst  in  1`: synchronous, active-high reset.
- `req  in  2`: burst request per requester. Level signal, held until `gnt`.
- `addr0`, `addr1  in  ADDR_W`: burst start address. Sampled on grant.
- `len0`, `len1  in  LEN_W`: burst byte count. Sampled on grant.
- `gnt  out  2`: one-cycle pulse; the request is accepted.
- `rd_valid  out  2`: byte available for the owning requester.
- `rd_ready  in  2`: requester accepts the byte.
- `rd_data  out  8`: shared byte bus. Meaningful only where `rd_valid` is set.
- `done  out  2`: one-cycle pulse; the burst has completed.
- `fr_read  out  1`: read strobe to the flash reader.
- `fr_addr  out  ADDR_W`: byte address to the flash reader.
- `fr_ready  in  1`: reader completion pulse.
- `fr_data  in  8`: reader data. Valid when `fr_ready`=1.

## Operation
- States:
  - SETTLE: count `SETTLE_CYC`, then go to IDLE.
  - IDLE: arbitrate.
  - ISSUE: drive `fr_read`=1 for 1 cycle.
  - WAIT: wait for `fr_ready`.
  - DELIVER: hold `rd_valid` until `rd_ready`.
  - DONE: pulse `done`.
- IDLE with any `req` bit set:
  - Select the owner, pulse `gnt[owner]`, latch that requester's addr/len into `cur_addr`/`remain`.
  - If `len`=0, go directly to DONE (no flash access). Otherwise go to ISSUE.
- ISSUE: `fr_read`=1 and `fr_addr`=`cur_addr` for exactly one cycle, then go to WAIT. `fr_addr` is held stable until `fr_ready`.
- WAIT, on `fr_ready`: latch `fr_data` into `rd_data`, set `rd_valid[owner]`, go to DELIVER.
- DELIVER, on `rd_ready[owner]`:
  - Clear `rd_valid`.
  - `cur_addr` += 1, wrapping modulo 2^ADDR_W (0xFFFFFF → 0x000000).
  - `remain` -= 1.
  - If `remain` was 1, go to DONE; else go to ISSUE.
- DONE: pulse `done[owner]` for one cycle, return to IDLE. The owner's `req` may remain high; it is re-arbitrated normally.
- `rd_ready` of the non-owner and `rd_ready` outside DELIVER are ignored.
- `fr_ready` outside WAIT is ignored; no state change.
- Requester lowering `req` before `gnt`: the request is withdrawn, with no side effects. `req` changes after `gnt` are ignored until DONE.
- Reset mid-burst:
  - All outputs go to reset values and the state goes to SETTLE. Any in-flight byte is discarded; no `done` is issued.
  - SETTLE guarantees the reader (which has no reset) has returned to idle before the next `fr_read`.

## Timing
- Reset values: `gnt`=0, `rd_valid`=0, `rd_data`=0, `done`=0, `fr_read`=0, `fr_addr`=0. State=SETTLE, RR pointer=1.
- `req` high in IDLE → `gnt` on the next edge. `fr_read` follows 1 cycle after `gnt`.
- `fr_ready` → `rd_valid` high on the next cycle.
- With `rd_ready` tied high: per-byte overhead is ISSUE + WAIT + 1 DELIVER cycle over reader latency. There is 1 cycle from the DELIVER handshake to the next `fr_read`.
- `done` asserts 1 cycle after the last DELIVER handshake. For `len`=0, `done` asserts 1 cycle after `gnt`.
- Never more than one outstanding `fr_read`; `fr_read` is never high two consecutive cycles.

## Configuration
- `FLASH_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer records the last owner.
  - When both requesters request, the non-last owner wins.
  - After reset, requester 0 wins first.
- `FLASH_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins simultaneous requests; the pointer logic is removed.

## Structure
- Shared package `flash_arb_pkg`:
  - state enum: SETTLE, IDLE, ISSUE, WAIT, DELIVER, DONE;
  - flash command constant 8'hBB;
  - reader worst-case latency constant (28) used to check `SETTLE_CYC`.
- One sub-module: `flash_arb_pick`. It takes `req[1:0]` and the last-owner pointer and outputs the owner index plus a valid flag. It contains the `FLASH_ARB_RR_EN` conditional.

## Test plan
- Single burst: req0, addr0=0x400000, len0=3, `rd_ready`=1. Expect:
  - `fr_addr` sequence 0x400000, 0x400001, 0x400002;
  - three `rd_valid[0]` pulses with the model bytes;
  - `done[0]` once; `rd_valid[1]` never set.
- Contention: req0 and req1 both rise in the same cycle, len=2 each. RR build: gnt0, then gnt1, then gnt0 if req0 is still held. Non-RR build: requester 0 repeats while held.
- Backpressure: hold `rd_ready[1]`=0 for 50 cycles mid-burst. Expect:
  - `rd_valid[1]` and `rd_data` stable;
  - no `fr_read` until the handshake.
- Wrap and zero length: addr1=0xFFFFFF, len1=2 → `fr_addr` 0xFFFFFF then 0x000000. Then len0=0 → `gnt[0]`, `done[0]` on the next cycle, no `fr_read`.
- Reset mid-WAIT: assert `rst` 1 cycle after `fr_read`. Expect:
  - no `rd_valid` or `done`;
  - the stray `fr_ready` ignored;
  - no `fr_read` until `SETTLE_CYC` cycles after reset release;
  - the next burst returns correct data.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash burst arbiter.
// Holds the FSM state encoding and the flash reader timing limits.
package flash_arb_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELIVER,
        ST_DONE
    } arb_state_t;

    // Single-byte DSPI read command issued by the reader for every fr_read.
    localparam logic [7:0] FLASH_READ_CMD = 8'hBB;

    // Longest reader transaction in cycles; the post-reset quiet time must exceed it.
    localparam int READER_MAX_LAT = 28;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/flash_arb_pick.sv
// Owner selection for the two-requester flash arbiter.
// FLASH_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module flash_arb_pick
    import flash_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       owner,
    output logic       valid
);

    assign valid = |req;

`ifdef FLASH_ARB_RR_EN
    // On a tie the requester that did not own the reader last time wins.
    assign owner = (req == 2'b11) ? ~last : req[1];
`else
    logic unused_last;
    assign unused_last = last;
    assign owner       = ~req[0];
`endif

endmodule

// File: rtl/flash_burst_arbiter.sv
// Shares one DSPI flash byte reader between two burst requesters.
// Build option: FLASH_ARB_RR_EN enables round-robin arbitration (fixed priority otherwise).
module flash_burst_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 8,
    parameter int SETTLE_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic [1:0]        gnt,
    output logic [1:0]        rd_valid,
    input  logic [1:0]        rd_ready,
    output logic [7:0]        rd_data,
    output logic [1:0]        done,
    output logic              fr_read,
    output logic [ADDR_W-1:0] fr_addr,
    input  logic              fr_ready,
    input  logic [7:0]        fr_data
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    if (SETTLE_CYC <= READER_MAX_LAT) begin : g_settle_check
        $error("SETTLE_CYC must exceed the flash reader worst-case latency");
    end

    arb_state_t        state;
    logic [CNT_W-1:0]  settle_cnt;
    logic              owner;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remain;
    logic              last_owner;
    logic              pick_owner;
    logic              pick_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

`ifndef FLASH_ARB_RR_EN
    assign last_owner = 1'b1;
`endif

    flash_arb_pick u_pick (
        .req   (req),
        .last  (last_owner),
        .owner (pick_owner),
        .valid (pick_valid)
    );

    assign sel_addr = pick_owner ? addr1 : addr0;
    assign sel_len  = pick_owner ? len1  : len0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            owner      <= 1'b0;
            cur_addr   <= '0;
            remain     <= '0;
            gnt        <= '0;
            rd_valid   <= '0;
            rd_data    <= '0;
            done       <= '0;
            fr_read    <= 1'b0;
            fr_addr    <= '0;
`ifdef FLASH_ARB_RR_EN
            last_owner <= 1'b1;
`endif
        end else begin
            // NOTE: pulse outputs default low every cycle; the state cases only raise them.
            gnt     <= '0;
            done    <= '0;
            fr_read <= 1'b0;
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_owner;
                        gnt      <= onehot2(pick_owner);
                        cur_addr <= sel_addr;
                        remain   <= sel_len;
                        state    <= (sel_len == '0) ? ST_DONE : ST_ISSUE;
`ifdef FLASH_ARB_RR_EN
                        last_owner <= pick_owner;
`endif
                    end
                end
                ST_ISSUE: begin
                    fr_read <= 1'b1;
                    fr_addr <= cur_addr;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fr_ready) begin
                        rd_data  <= fr_data;
                        rd_valid <= onehot2(owner);
                        state    <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (rd_ready[owner]) begin
                        rd_valid <= '0;
                        cur_addr <= cur_addr + ADDR_W'(1);
                        remain   <= remain - LEN_W'(1);
                        state    <= (remain == LEN_W'(1)) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    done  <= onehot2(owner);
                    state <= ST_IDLE;
                end
                default: state <= ST_SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_burst_arbiter.sv
// Scoreboard bench for flash_burst_arbiter with a behavioural flash reader.
// Expectations are queued at stimulus time and popped as the DUT acts.
module tb_flash_burst_arbiter;
    import flash_arb_pkg::*;

    localparam int ADDR_W     = 24;
    localparam int LEN_W      = 8;
    localparam int SETTLE_CYC = 32;
    localparam int RD_LAT     = 6;
    localparam int BUDGET     = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [LEN_W-1:0]  len0, len1;
    logic [1:0]        gnt, rd_valid, rd_ready, done;
    logic [7:0]        rd_data;
    logic              fr_read;
    logic [ADDR_W-1:0] fr_addr;
    logic              fr_ready;
    logic [7:0]        fr_data;

    typedef struct {
        logic       owner;
        logic [7:0] data;
    } exp_byte_t;

    logic              exp_gnt[$];
    logic              exp_done[$];
    logic [ADDR_W-1:0] exp_addr[$];
    exp_byte_t         exp_byte[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int gnt_count[2];
    int done_count[2];
    int hs_count[2];
    int gnt_cyc_o[2];
    int done_cyc[2];
    int frread_count = 0;
    int gnt_cyc = 0;
    int gnt_to_read = -1;
    logic gnt_pending = 1'b0;
    logic prev_fr_read = 1'b0;

    flash_burst_arbiter #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr0    (addr0),
        .addr1    (addr1),
        .len0     (len0),
        .len1     (len1),
        .gnt      (gnt),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .done     (done),
        .fr_read  (fr_read),
        .fr_addr  (fr_addr),
        .fr_ready (fr_ready),
        .fr_data  (fr_data)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h3C;
    endfunction

    // Behavioural reader: answers each fr_read after RD_LAT cycles, ignoring reset.
    initial begin
        logic [ADDR_W-1:0] a;
        fr_ready = 1'b0;
        fr_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (fr_read) begin
                a = fr_addr;
                repeat (RD_LAT) @(posedge clk);
                #1;
                fr_ready = 1'b1;
                fr_data  = model_byte(a);
                @(posedge clk);
                #1;
                fr_ready = 1'b0;
                fr_data  = 8'h00;
            end
        end
    end

    task automatic monitor_cycle();
        logic      idx;
        exp_byte_t eb;
        if (gnt != 2'b00) begin
            idx = gnt[1];
            gnt_count[idx]++;
            gnt_cyc_o[idx] = cyc;
            gnt_cyc = cyc;
            gnt_pending = 1'b1;
            if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
            else check("gnt_owner", 32'(gnt), 32'(onehot2(exp_gnt.pop_front())));
        end
        if (fr_read) begin
            check("fr_read_back_to_back", 32'(prev_fr_read), 0);
            frread_count++;
            if (gnt_pending) begin
                gnt_to_read = cyc - gnt_cyc;
                gnt_pending = 1'b0;
            end
            if (exp_addr.size() == 0) check("fr_read_unexpected", 32'(fr_read), 0);
            else check("fr_addr", 32'(fr_addr), 32'(exp_addr.pop_front()));
        end
        prev_fr_read = fr_read;
        if ((rd_valid & rd_ready) != 2'b00) begin
            idx = rd_valid[1];
            hs_count[idx]++;
            if (exp_byte.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 0);
            end else begin
                eb = exp_byte.pop_front();
                check("rd_valid_owner", 32'(rd_valid), 32'(onehot2(eb.owner)));
                check("rd_data", 32'(rd_data), 32'(eb.data));
            end
        end
        if (done != 2'b00) begin
            idx = done[1];
            done_count[idx]++;
            done_cyc[idx] = cyc;
            if (exp_done.size() == 0) check("done_unexpected", 32'(done), 0);
            else check("done_owner", 32'(done), 32'(onehot2(exp_done.pop_front())));
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) monitor_cycle();
    end

    function automatic int count_of(input int kind, input logic o);
        case (kind)
            0:       return gnt_count[o];
            1:       return done_count[o];
            2:       return hs_count[o];
            default: return frread_count;
        endcase
    endfunction

    // Returns just after a posedge once the monitor has seen the event.
    task automatic wait_event(input string tag, input int kind, input logic o, input int target);
        int n;
        n = 0;
        while (count_of(kind, o) < target && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (count_of(kind, o) < target) check(tag, 32'(count_of(kind, o)), 32'(target));
    endtask

    task automatic expect_burst(input logic o, input logic [ADDR_W-1:0] a, input int len);
        logic [ADDR_W-1:0] ai;
        exp_gnt.push_back(o);
        for (int i = 0; i < len; i++) begin
            ai = a + ADDR_W'(i);
            exp_addr.push_back(ai);
            exp_byte.push_back('{owner: o, data: model_byte(ai)});
        end
        exp_done.push_back(o);
    endtask

    task automatic set_req_args(input logic o, input logic [ADDR_W-1:0] a, input int len);
        if (o) begin
            addr1 = a;
            len1  = LEN_W'(len);
        end else begin
            addr0 = a;
            len0  = LEN_W'(len);
        end
    endtask

    task automatic run_burst(input logic o, input logic [ADDR_W-1:0] a, input int len);
        int g, d;
        expect_burst(o, a, len);
        set_req_args(o, a, len);
        g = gnt_count[o];
        d = done_count[o];
        req[o] = 1'b1;
        wait_event("gnt_timeout", 0, o, g + 1);
        req[o] = 1'b0;
        wait_event("done_timeout", 1, o, d + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0, g1, d0, d1, h, n, rel;
        rst      = 1'b1;
        req      = 2'b00;
        rd_ready = 2'b11;
        addr0    = '0;
        addr1    = '0;
        len0     = '0;
        len1     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fr_read", 32'(fr_read), 0);
        check("rst_fr_addr", 32'(fr_addr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single three-byte burst for requester 0.
        run_burst(1'b0, 24'h400000, 3);
        check("gnt_to_fr_read", 32'(gnt_to_read), 1);
        check("single_done_count", 32'(done_count[0]), 1);
        check("single_no_rd1", 32'(hs_count[1]), 0);

        // Backpressure on requester 1 in the middle of its burst.
        expect_burst(1'b1, 24'h2000F0, 3);
        set_req_args(1'b1, 24'h2000F0, 3);
        g1 = gnt_count[1];
        d1 = done_count[1];
        h  = hs_count[1];
        req[1] = 1'b1;
        wait_event("bp_gnt_timeout", 0, 1'b1, g1 + 1);
        req[1] = 1'b0;
        wait_event("bp_hs_timeout", 2, 1'b1, h + 1);
        rd_ready = 2'b01;
        n = 0;
        @(negedge clk);
        while (!rd_valid[1] && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(rd_valid[1]), 1);
        for (int i = 0; i < 50; i++) begin
            check("bp_rd_valid", 32'(rd_valid), 32'(2'b10));
            check("bp_rd_data", 32'(rd_data), 32'(model_byte(24'h2000F1)));
            check("bp_no_fr_read", 32'(fr_read), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rd_ready = 2'b11;
        wait_event("bp_done_timeout", 1, 1'b1, d1 + 1);

        // Contention: both requesters rise together with two-byte bursts.
        set_req_args(1'b0, 24'h000100, 2);
        set_req_args(1'b1, 24'h123456, 2);
        g0 = gnt_count[0];
        g1 = gnt_count[1];
        d0 = done_count[0];
        d1 = done_count[1];
`ifdef FLASH_ARB_RR_EN
        expect_burst(1'b0, 24'h000100, 2);
        expect_burst(1'b1, 24'h123456, 2);
        expect_burst(1'b0, 24'h000100, 2);
        req = 2'b11;
        wait_event("ct_gnt0_timeout", 0, 1'b0, g0 + 1);
        wait_event("ct_gnt1_timeout", 0, 1'b1, g1 + 1);
        req[1] = 1'b0;
        wait_event("ct_gnt0b_timeout", 0, 1'b0, g0 + 2);
        req[0] = 1'b0;
`else
        expect_burst(1'b0, 24'h000100, 2);
        expect_burst(1'b0, 24'h000100, 2);
        expect_burst(1'b1, 24'h123456, 2);
        req = 2'b11;
        wait_event("ct_gnt0_timeout", 0, 1'b0, g0 + 1);
        wait_event("ct_gnt0b_timeout", 0, 1'b0, g0 + 2);
        req[0] = 1'b0;
        wait_event("ct_gnt1_timeout", 0, 1'b1, g1 + 1);
        req[1] = 1'b0;
`endif
        wait_event("ct_done0_timeout", 1, 1'b0, d0 + 2);
        wait_event("ct_done1_timeout", 1, 1'b1, d1 + 1);

        // Address wrap, then a zero-length burst.
        run_burst(1'b1, 24'hFFFFFF, 2);
        n = frread_count;
        run_burst(1'b0, 24'h00ABCD, 0);
        check("zero_len_done_gap", 32'(done_cyc[0] - gnt_cyc_o[0]), 1);
        check("zero_len_no_fr_read", 32'(frread_count), 32'(n));

        // Reset while the reader is busy; the stray fr_ready lands during settle.
        exp_gnt.push_back(1'b1);
        exp_addr.push_back(24'h300000);
        set_req_args(1'b1, 24'h300000, 4);
        g1 = gnt_count[1];
        n  = frread_count;
        req[1] = 1'b1;
        wait_event("rst_gnt_timeout", 0, 1'b1, g1 + 1);
        req[1] = 1'b0;
        wait_event("rst_fr_read_timeout", 3, 1'b0, n + 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel = cyc;
        d1 = done_count[1];
        h  = hs_count[1];
        expect_burst(1'b1, 24'h300010, 2);
        set_req_args(1'b1, 24'h300010, 2);
        g1 = gnt_count[1];
        req[1] = 1'b1;
        wait_event("post_rst_gnt_timeout", 0, 1'b1, g1 + 1);
        req[1] = 1'b0;
        check("settle_gap", 32'(gnt_cyc_o[1] - rel), 32'(SETTLE_CYC + 1));
        wait_event("post_rst_done_timeout", 1, 1'b1, d1 + 1);
        check("post_rst_bytes", 32'(hs_count[1] - h), 2);

        repeat (4) @(posedge clk);
        check("left_gnt", 32'(exp_gnt.size()), 0);
        check("left_addr", 32'(exp_addr.size()), 0);
        check("left_byte", 32'(exp_byte.size()), 0);
        check("left_done", 32'(exp_done.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
